// File: rtl/norm_sched.sv
// norm_sched: round-robin arbiter in front of one shared normalizer
// (leading-zero count + left shift) for the DSP add-path lanes.
// Optional feature macro: NORM_FAST_PATH_EN. It sends operands that are
// already normalized (MSB=1) from IDLE straight to OUT.
module norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int MANT_W  = 24,
  parameter int EXP_W   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LZ_W   = $clog2(MANT_W)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*MANT_W-1:0] req_mant,
  input  logic [NUM_REQ*EXP_W-1:0]  req_exp,
  input  logic [NUM_REQ-1:0]        req_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANT_W-1:0]         out_mant,
  output logic [EXP_W-1:0]          out_exp,
  output logic                      out_sign,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_zero,
  output logic                      out_uflow
);

  localparam int CW = EXP_W + LZ_W;

  typedef enum logic [1:0] {IDLE, ENC, SHIFT, OUT} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_reg;
  logic [MANT_W-1:0] mant_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic              sign_reg;
  logic [ID_W-1:0]   id_reg;
  logic [LZ_W-1:0]   lzc_reg;
  logic              zero_reg;

  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic              uflow_cond;
  logic [EXP_W-1:0]  exp_dec;

  // Count of zeros above the first set bit; MANT_W for an all-zero input
  // (that case is carried separately by the zero flag).
  function automatic logic [LZ_W-1:0] lead_zeros(input logic [MANT_W-1:0] m);
    logic [LZ_W-1:0] n;
    logic            hit;
    n   = '0;
    hit = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!hit) begin
        if (m[i]) hit = 1'b1;
        else      n   = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  // Round-robin search: first valid lane strictly after the last grant, wrapping.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign sel_mant = req_mant[grant_id*MANT_W +: MANT_W];
  assign sel_exp  = req_exp[grant_id*EXP_W +: EXP_W];

  // Already-normalized operands (lzc==0) never underflow, even with exp==0.
  assign uflow_cond = (lzc_reg != '0) && (CW'(lzc_reg) >= CW'(exp_reg));
  assign exp_dec    = exp_reg - EXP_W'(lzc_reg);

  // Accept pulse only while idle; held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (reset_n && state_reg == IDLE && grant_any) req_ready[grant_id] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
`ifdef NORM_FAST_PATH_EN
          state_next = sel_mant[MANT_W-1] ? OUT : ENC;
`else
          state_next = ENC;
`endif
        end
      end
      ENC:     state_next = SHIFT;
      SHIFT:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Operand latch, encode, shift and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg    <= ID_W'(NUM_REQ - 1);
      mant_reg  <= '0;
      exp_reg   <= '0;
      sign_reg  <= 1'b0;
      id_reg    <= '0;
      lzc_reg   <= '0;
      zero_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_id    <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            mant_reg <= sel_mant;
            exp_reg  <= sel_exp;
            sign_reg <= req_sign[grant_id];
            id_reg   <= grant_id;
            rr_reg   <= grant_id;
`ifdef NORM_FAST_PATH_EN
            if (sel_mant[MANT_W-1]) begin
              out_mant  <= sel_mant;
              out_exp   <= sel_exp;
              out_sign  <= req_sign[grant_id];
              out_id    <= grant_id;
              out_zero  <= 1'b0;
              out_uflow <= 1'b0;
              out_valid <= 1'b1;
            end
`endif
          end
        end
        ENC: begin
          lzc_reg  <= lead_zeros(mant_reg);
          zero_reg <= (mant_reg == '0);
        end
        SHIFT: begin
          out_sign  <= sign_reg;
          out_id    <= id_reg;
          out_valid <= 1'b1;
          if (zero_reg) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b1;
            out_uflow <= 1'b0;
          end else if (uflow_cond) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b1;
            out_uflow <= 1'b1;
          end else begin
            out_mant  <= mant_reg << lzc_reg;
            out_exp   <= exp_dec;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sched.sv
// Scoreboard bench for norm_sched: a reference model predicts each grant
// and normalized result; a negedge monitor checks grants and outputs.
module tb_norm_sched;
  localparam int NR = 4;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int IW = 2;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*MW-1:0] req_mant;
  logic [NR*EW-1:0] req_exp;
  logic [NR-1:0]   req_sign;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   out_mant;
  logic [EW-1:0]   out_exp;
  logic            out_sign;
  logic [IW-1:0]   out_id;
  logic            out_zero;
  logic            out_uflow;

  norm_sched #(.NUM_REQ(NR), .MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mant(req_mant), .req_exp(req_exp), .req_sign(req_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_id(out_id), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic [IW-1:0] id;
    logic          zero;
    logic          uflow;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   mon_en = 0;
  bit   busy   = 0;
  int   rr     = NR - 1;
  bit   head_seen = 0;
  bit   intv_mode = 0;
  int   last_first = -1;

  task automatic check(input bit ok, input string name, input string info);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, info);
  endtask

  // Reference normalization: double the mantissa until its top bit is set.
  function automatic exp_t model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                 input logic s, input int id, input int acc);
    exp_t r;
    logic [MW-1:0] mm;
    int sh;
    r.sign = s; r.id = IW'(id); r.acc = acc;
    r.mant = '0; r.exp = '0; r.zero = 1'b0; r.uflow = 1'b0;
`ifdef NORM_FAST_PATH_EN
    r.lat = m[MW-1] ? 1 : 3;
`else
    r.lat = 3;
`endif
    if (m == 0) begin
      r.zero = 1'b1;
    end else begin
      mm = m; sh = 0;
      while (mm < (1 << (MW - 1))) begin mm = mm * 2; sh++; end
      if (sh > 0 && sh >= int'(e)) begin
        r.zero = 1'b1; r.uflow = 1'b1;
      end else begin
        r.mant = mm; r.exp = EW'(int'(e) - sh);
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mant();
    logic [MW-1:0] r;
    r = MW'($urandom);
    case ($urandom_range(0, 4))
      0: return '0;
      1: return r | (MW'(1) << (MW - 1));
      2: return r >> $urandom_range(0, MW - 1);
      3: return MW'(1) << $urandom_range(0, MW - 1);
      default: return r;
    endcase
  endfunction

  function automatic logic [EW-1:0] rnd_exp();
    if ($urandom_range(0, 3) == 0) return EW'($urandom_range(0, 30));
    return EW'($urandom_range(0, 255));
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  // Monitor: checks outputs against the scoreboard head and grants against the model.
  initial begin
    exp_t h;
    logic [NR-1:0] exp_rdy;
    int g, idx;
    bit rel;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        rel = 0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            check(0, "spurious_out", "out_valid=1 with no pending accept");
          end else begin
            h = sb[0];
            if (!head_seen) begin
              head_seen = 1;
              check(cyc - h.acc == h.lat, "latency",
                    $sformatf("got %0d cycles, required %0d", cyc - h.acc, h.lat));
              if (intv_mode && last_first >= 0)
                check(cyc - last_first == 4, "interval",
                      $sformatf("got %0d cycles, required 4", cyc - last_first));
              last_first = cyc;
            end
            check({out_mant, out_exp, out_sign, out_id, out_zero, out_uflow} ==
                  {h.mant, h.exp, h.sign, h.id, h.zero, h.uflow}, "result",
                  $sformatf("got m=%h e=%0d s=%0d id=%0d z=%0d u=%0d, required m=%h e=%0d s=%0d id=%0d z=%0d u=%0d",
                            out_mant, out_exp, out_sign, out_id, out_zero, out_uflow,
                            h.mant, h.exp, h.sign, h.id, h.zero, h.uflow));
            if (out_ready) begin
              void'(sb.pop_front());
              head_seen = 0;
              rel = 1;
            end
          end
        end
        exp_rdy = '0;
        g = -1;
        if (!busy) begin
          for (int k = 1; k <= NR; k++) begin
            idx = (rr + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check(req_ready == exp_rdy, "grant",
              $sformatf("got req_ready=%b, required %b", req_ready, exp_rdy));
        if (g >= 0) begin
          sb.push_back(model(req_mant[g*MW +: MW], req_exp[g*EW +: EW], req_sign[g], g, cyc));
          rr = g;
          busy = 1;
        end
        if (rel) busy = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || sb.size() != 0) && t < 300) begin @(posedge clk); t++; end
    if (t >= 300) check(0, "timeout_idle", "DUT did not drain within 300 cycles");
  endtask

  task automatic send(input int lane, input logic [MW-1:0] m, input logic [EW-1:0] e,
                      input logic s);
    wait_idle();
    @(posedge clk); #1;
    req_mant[lane*MW +: MW] = m;
    req_exp[lane*EW +: EW]  = e;
    req_sign[lane]          = s;
    req_valid               = NR'(1) << lane;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic randomize_lanes(input bit no_msb);
    for (int i = 0; i < NR; i++) begin
      req_mant[i*MW +: MW] = no_msb ? (rnd_mant() & {1'b0, {(MW-1){1'b1}}}) : rnd_mant();
      req_exp[i*EW +: EW]  = rnd_exp();
      req_sign[i]          = 1'($urandom);
    end
  endtask

  initial begin
    int t;
    reset_n = 0; req_valid = '0; req_mant = '0; req_exp = '0; req_sign = '0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check({out_valid, out_mant, out_exp, out_sign, out_id, out_zero, out_uflow, req_ready} == '0,
          "reset_state", $sformatf("got out_valid=%0d out_mant=%h req_ready=%b, required all 0",
                                   out_valid, out_mant, req_ready));
    @(negedge clk) reset_n = 1;

    // Reset asserted while the first operand sits in ENC.
    @(posedge clk); #1;
    req_mant[0 +: MW] = 24'h000F00; req_exp[0 +: EW] = 8'd40; req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    #1 reset_n = 0;
    req_valid = '1;
    #1;
    check({out_valid, out_mant, out_exp, out_sign, out_id, out_zero, out_uflow, req_ready} == '0,
          "reset_mid_enc", $sformatf("got out_valid=%0d out_mant=%h req_ready=%b, required all 0",
                                     out_valid, out_mant, req_ready));
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check(out_valid == 0, "no_out_after_reset",
            $sformatf("got out_valid=%0d, required 0", out_valid));
    end
    rr = NR - 1; busy = 0; head_seen = 0; sb.delete();
    mon_en = 1;

    // Single lane normalization.
    send(1, 24'h000F00, 8'd40, 1'b1);
    // Zero input and exponent underflow.
    send(0, 24'h000000, 8'd77, 1'b0);
    send(0, 24'h000001, 8'd10, 1'b1);
    // Already normalized, including exp==0 which must not underflow.
    send(2, 24'h800001, 8'd5, 1'b0);
    send(3, 24'hC00000, 8'd0, 1'b1);
    wait_idle();

    // All lanes valid, out_ready high: round-robin order, 4-cycle spacing.
    @(posedge clk); #1;
    last_first = -1; intv_mode = 1;
    for (int i = 0; i < 24; i++) begin
      randomize_lanes(1'b1);
      req_valid = '1;
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle();
    intv_mode = 0;

    // Backpressure: hold the result for 6 cycles while every lane requests.
    send(3, 24'h000123, 8'd50, 1'b0);
    out_ready = 0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) check(0, "timeout_out", "out_valid not seen within 20 cycles");
    randomize_lanes(1'b0);
    req_valid = '1;
    repeat (6) @(posedge clk);
    #1 out_ready = 1;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      randomize_lanes(1'b0);
      req_valid = NR'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check(sb.size() == 0, "scoreboard_empty",
          $sformatf("got %0d pending results, required 0", sb.size()));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
